icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between the pipelined core's fetch port (pcF/instrF)
//  and a slower word-wide instruction memory with a request/acknowledge handshake.
//  Hit: instrF is returned combinationally in the same cycle. Miss: stall_ic is asserted and the

---
 rtl/icache_dm_pkg.sv | 19 +
 rtl/icache_store.sv | 60 ++++++
 rtl/icache_dm.sv | 119 +++++++++++
 tb/tb_icache_dm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state codes
// and the address-field width helper used by the cache top and its storage.
`timescale 1ns/1ps
package icache_dm_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REFILL = 2'd1,
        IC_DONE   = 2'd2
    } ic_state_e;

    // Tag width after removing byte, word-in-line and index fields.
    function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
        return XLEN - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Tag RAM, valid bits and data RAM for icache_dm: combinational read,
// synchronous word/tag writes and a global synchronous valid clear.
`timescale 1ns/1ps
module icache_store
    import icache_dm_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    localparam int unsigned IB = $clog2(LINES),
    localparam int unsigned OB = $clog2(WORDS),
    localparam int unsigned TW = tag_width(LINES, WORDS)
) (
    input  logic          clk,
    input  logic [IB-1:0] rd_idx,
    input  logic [OB-1:0] rd_word,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_data,
    input  logic [IB-1:0] wr_idx,
    input  logic          data_we,
    input  logic [OB-1:0] wr_word,
    input  logic [31:0]   wr_data,
    input  logic          tag_we,
    input  logic [TW-1:0] wr_tag,
    input  logic          inv_we,
    input  logic          clr_all
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_ram  [LINES];
    logic [31:0]      data_ram [LINES][WORDS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_ram[rd_idx];
    assign rd_data  = data_ram[rd_idx][rd_word];

    // The global clear has priority so reset and flush always win over a fill.
    always_ff @(posedge clk) begin
        if (clr_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end else if (inv_we) begin
            valid[wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_ram[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_ram[wr_idx][wr_word] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, miss refill of a
// whole line one word per memory acknowledge.
`timescale 1ns/1ps
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        flush_ic,
    output logic [31:0] instrF,
    output logic        stall_ic,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned OB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = tag_width(LINES, WORDS);
    localparam logic [OB-1:0] CNT_LAST = OB'(WORDS - 1);

    ic_state_e       state;
    logic [OB-1:0]   cnt;
    logic [OB-1:0]   cnt_nxt;
    logic [29-OB:0]  miss_line;
    logic [IB-1:0]   pc_idx;
    logic [OB-1:0]   pc_word;
    logic [TW-1:0]   pc_tag;
    logic [IB-1:0]   miss_idx;
    logic [TW-1:0]   miss_tag;
    logic            rd_valid;
    logic [TW-1:0]   rd_tag;
    logic [31:0]     rd_data;
    logic            hit;
    logic            fill_ack;
    logic [1:0]      unused_pc;

    assign unused_pc = pcF[1:0];
    assign pc_word   = pcF[2 +: OB];
    assign pc_idx    = pcF[OB+2 +: IB];
    assign pc_tag    = pcF[31 -: TW];
    assign miss_idx  = miss_line[IB-1:0];
    assign miss_tag  = miss_line[29-OB -: TW];
    assign cnt_nxt   = cnt + OB'(1);

    assign hit      = rd_valid && (rd_tag == pc_tag) && (state == IC_IDLE);
    assign stall_ic = !hit;
    assign instrF   = hit ? rd_data : '0;
    assign fill_ack = (state == IC_REFILL) && mem_ack && !flush_ic;

    // Idle misses invalidate the live-PC line; fill writes target the captured miss line.
    icache_store #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) u_store (
        .clk     (clk),
        .rd_idx  (pc_idx),
        .rd_word (pc_word),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_idx  ((state == IC_IDLE) ? pc_idx : miss_idx),
        .data_we (fill_ack),
        .wr_word (cnt),
        .wr_data (mem_rdata),
        .tag_we  (fill_ack && (cnt == CNT_LAST)),
        .wr_tag  (miss_tag),
        .inv_we  ((state == IC_IDLE) && !hit),
        .clr_all (!reset || flush_ic)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IC_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            miss_line <= '0;
        end else begin
            case (state)
                IC_IDLE: begin
                    if (!hit) begin
                        miss_line <= pcF[31:OB+2];
                        mem_addr  <= {pcF[31:OB+2], {(OB+2){1'b0}}};
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        state     <= IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    if (flush_ic) begin
                        mem_req <= 1'b0;
                        state   <= IC_IDLE;
                    end else if (mem_ack) begin
                        cnt <= cnt_nxt;
                        if (cnt == CNT_LAST) begin
                            mem_req <= 1'b0;
                            state   <= IC_DONE;
                        end else begin
                            mem_addr <= {miss_line, cnt_nxt, 2'b00};
                        end
                    end
                end
                IC_DONE: begin
                    state <= IC_IDLE;
                end
                default: begin
                    state <= IC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomised self-checking bench for icache_dm against a line-level cache model
// and a word-addressed reference memory.
`timescale 1ns/1ps
module tb_icache_dm;

    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_ic = 1'b0;
    logic [31:0] pcF = '0;
    logic [31:0] instrF;
    logic        stall_ic;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        resp_ack = 1'b0;
    logic [31:0] resp_data = '0;
    logic        late_ack = 1'b0;

    assign mem_ack   = resp_ack | late_ack;
    assign mem_rdata = late_ack ? 32'hDEAD_BEEF : resp_data;

    always #5 clk = ~clk;

    icache_dm #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pcF      (pcF),
        .flush_ic (flush_ic),
        .instrF   (instrF),
        .stall_ic (stall_ic),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    logic [31:0]  mem_data [256];
    logic [31:0]  addr_q [$];
    int unsigned  ack_count = 0;
    int unsigned  delay_min = 1;
    int unsigned  delay_max = 1;
    int unsigned  n_pass = 0;
    int unsigned  n_total = 0;

    bit           mvalid [LINES];
    int unsigned  mtag   [LINES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory responder: acks a pending request after a (possibly random) wait.
    initial begin : responder
        int unsigned waited;
        int unsigned dly;
        waited = 0;
        dly = 1;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (mem_req) begin
                if (waited >= dly) begin
                    resp_ack  = 1'b1;
                    resp_data = mem_data[mem_addr[9:2]];
                    addr_q.push_back(mem_addr);
                    ack_count++;
                    waited = 0;
                    dly = $urandom_range(delay_max, delay_min);
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    // Called at a falling edge; leaves at the falling edge after the word is delivered.
    task automatic model_access(input logic [31:0] pc, input string tag, output int unsigned cycles);
        int unsigned li;
        int unsigned lt;
        logic [31:0] base;
        bit          exp_hit;
        int unsigned ack0;
        li   = (pc / (4 * WORDS)) % LINES;
        lt   = pc / (4 * WORDS * LINES);
        base = pc - (pc % (4 * WORDS));
        exp_hit = mvalid[li] && (mtag[li] == lt);
        ack0 = ack_count;
        addr_q.delete();
        pcF = pc;
        #1;
        if (exp_hit) check({tag, " req on hit"}, 32'(mem_req), 32'd0);
        else         check({tag, " instr on miss"}, instrF, 32'd0);
        cycles = 0;
        while (stall_ic !== 1'b0 && cycles < 400) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check({tag, " stall"}, 32'(stall_ic), 32'd0);
        check({tag, " instr"}, instrF, mem_data[pc[9:2]]);
        if (exp_hit) begin
            check({tag, " hit cycles"}, cycles, 32'd0);
        end else begin
            check({tag, " ack count"}, ack_count - ack0, WORDS);
            for (int i = 0; i < int'(WORDS) && i < addr_q.size(); i++)
                check({tag, " fill addr"}, addr_q[i], base + 32'(4 * i));
            mvalid[li] = 1'b1;
            mtag[li]   = lt;
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int unsigned cyc;
        int unsigned ack0;
        bit          found;

        for (int i = 0; i < 256; i++) mem_data[i] = 32'(i * 4) ^ 32'hA5A5_0000;
        model_clear();

        // 1: reset state and cold miss
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset stall", 32'(stall_ic), 32'd1);
        check("reset req", 32'(mem_req), 32'd0);
        check("reset addr", mem_addr, 32'd0);
        check("reset instr", instrF, 32'd0);
        reset = 1'b1;
        model_access(32'h0, "t1 cold", cyc);
        check("t1 latency", cyc, 1 + WORDS * 2 + 1);

        // 2: hits after fill
        model_access(32'h8, "t2 hit8", cyc);
        model_access(32'hC, "t2 hitC", cyc);

        // 3: conflict on index 0
        model_access(32'h100, "t3 conflict", cyc);
        model_access(32'h0, "t3 refetch", cyc);

        // 4: flush on the second ack of a refill, then a stray ack
        pcF = 32'h40;
        ack0 = ack_count;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_ack && (ack_count - ack0 == 2)) begin
                found = 1'b1;
                break;
            end
        end
        check("t4 second ack seen", 32'(found), 32'd1);
        flush_ic = 1'b1;
        @(posedge clk);
        #1;
        flush_ic = 1'b0;
        model_clear();
        @(negedge clk);
        check("t4 req after flush", 32'(mem_req), 32'd0);
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        model_access(32'h40, "t4 reaccess", cyc);

        // 5: reset in the middle of a refill
        flush_ic = 1'b1;
        @(posedge clk);
        #1;
        flush_ic = 1'b0;
        model_clear();
        pcF = 32'h0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        check("t5 cnt2 reached", 32'(found), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("t5 req after reset", 32'(mem_req), 32'd0);
        check("t5 addr after reset", mem_addr, 32'd0);
        check("t5 stall after reset", 32'(stall_ic), 32'd1);
        reset = 1'b1;
        model_clear();
        model_access(32'h0, "t5 refill", cyc);

        // 6: random PCs, random ack delay, fresh memory image
        for (int i = 0; i < 256; i++) mem_data[i] = $urandom;
        flush_ic = 1'b1;
        @(posedge clk);
        #1;
        flush_ic = 1'b0;
        model_clear();
        @(negedge clk);
        delay_min = 0;
        delay_max = 5;
        for (int n = 0; n < 200; n++)
            model_access(32'($urandom_range(255, 0)) * 4, "t6 random", cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
